// File: rtl/uart_tlul_dbg_host.sv
// UART-driven TL-UL debug host: 'R'/'W' command frames in, status byte plus read data out.
// Optional response timeout is compiled in when UART_DBG_TIMEOUT_EN is defined.
package tlul_pkg;
  localparam logic [2:0] PutFullData = 3'h0;
  localparam logic [2:0] Get         = 3'h4;
  localparam logic [3:0] MuBi4False  = 4'h9;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  function automatic logic [6:0] fold7(input logic [63:0] v);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[i % 7] = r[i % 7] ^ v[i];
    return r;
  endfunction

  // Command/data integrity: parity folded over the protected request fields.
  function automatic tl_a_user_t tlul_cmd_intg_gen(input logic [31:0] addr, input logic [2:0] op,
                                                   input logic [3:0] mask, input logic [31:0] data);
    tl_a_user_t u;
    u = '0;
    u.instr_type = MuBi4False;
    u.cmd_intg   = fold7({21'h0, MuBi4False, addr, op, mask});
    u.data_intg  = fold7({32'h0, data});
    return u;
  endfunction
endpackage

module uart_tlul_dbg_host #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned TimeoutCycles  = 4096
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               uart_rx_i,
  output logic               uart_tx_o,
  output logic               busy_o,
  output tlul_pkg::tl_h2d_t  tl_o,
  input  tlul_pkg::tl_d2h_t  tl_i
);
  localparam int unsigned BitCycles = ClockFrequency / BaudRate;
  localparam int unsigned CW = $clog2(BitCycles);
  localparam logic [CW-1:0] BitLast  = CW'(BitCycles - 1);
  localparam logic [CW-1:0] HalfLast = CW'(BitCycles / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_RESP} state_e;
  state_e r_state, w_next;

  // Handshake: an a-channel beat transfers on a rising edge where a_valid && a_ready; a d-channel
  // beat transfers where d_valid && d_ready. a_valid and a_* stay stable until the transfer.

  // ---------------- UART receive ----------------
  logic          r_rx_s1, r_rx_s2, r_rx_s3, r_rx_act;
  logic [3:0]    r_rx_bitn;
  logic [CW-1:0] r_rx_cnt;
  logic [7:0]    r_rx_shift;
  logic          w_rx_sample, w_rx_valid, w_rx_ferr;

  assign w_rx_sample = r_rx_act && (r_rx_cnt == '0);
  assign w_rx_valid  = w_rx_sample && (r_rx_bitn == 4'd9) && r_rx_s2;
  assign w_rx_ferr   = w_rx_sample && (r_rx_bitn == 4'd9) && !r_rx_s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_s3 <= 1'b1;
      r_rx_act <= 1'b0; r_rx_bitn <= '0; r_rx_cnt <= '0; r_rx_shift <= '0;
    end else begin
      r_rx_s1 <= uart_rx_i; r_rx_s2 <= r_rx_s1; r_rx_s3 <= r_rx_s2;
      if (!r_rx_act) begin
        if (r_rx_s3 && !r_rx_s2) begin
          r_rx_act <= 1'b1; r_rx_cnt <= HalfLast; r_rx_bitn <= '0;
        end
      end else if (r_rx_cnt != '0) begin
        r_rx_cnt <= r_rx_cnt - 1'b1;
      end else begin
        r_rx_cnt  <= BitLast;
        r_rx_bitn <= r_rx_bitn + 1'b1;
        // Bit 0 is the mid-start check: a line already high again was a glitch.
        if (r_rx_bitn == 4'd0 && r_rx_s2) r_rx_act <= 1'b0;
        else if (r_rx_bitn >= 4'd1 && r_rx_bitn <= 4'd8) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        else if (r_rx_bitn == 4'd9) r_rx_act <= 1'b0;
      end
    end
  end

  // ---------------- UART transmit ----------------
  logic          r_tx_busy, r_tx_out, w_tx_ready, w_tx_load;
  logic [8:0]    r_tx_shift;
  logic [3:0]    r_tx_bitn;
  logic [CW-1:0] r_tx_cnt;
  logic [7:0]    w_tx_byte;

  // Ready in the last stop-bit cycle so consecutive bytes abut without an idle gap.
  assign w_tx_ready = !r_tx_busy || (r_tx_bitn == 4'd9 && r_tx_cnt == BitLast);
  assign uart_tx_o  = r_tx_out;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_busy <= 1'b0; r_tx_out <= 1'b1; r_tx_shift <= '1; r_tx_bitn <= '0; r_tx_cnt <= '0;
    end else if (w_tx_load) begin
      r_tx_busy <= 1'b1; r_tx_out <= 1'b0; r_tx_shift <= {1'b1, w_tx_byte};
      r_tx_bitn <= '0; r_tx_cnt <= '0;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == BitLast) begin
        r_tx_cnt <= '0;
        if (r_tx_bitn == 4'd9) begin
          r_tx_busy <= 1'b0;
        end else begin
          r_tx_out   <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[8:1]};
          r_tx_bitn  <= r_tx_bitn + 1'b1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- Response timeout ----------------
  logic w_timeout;
`ifdef UART_DBG_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] r_to_cnt;
  assign w_timeout = (r_to_cnt == TW'(TimeoutCycles - 1));
  always_ff @(posedge clk_i) begin
    if (rst_i || !(r_state == S_REQ || r_state == S_WAIT)) r_to_cnt <= '0;
    else if (!w_timeout) r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  localparam int unsigned unused_timeout_cycles = TimeoutCycles;
  assign w_timeout = 1'b0;
`endif

  // ---------------- Command datapath ----------------
  logic        r_is_write, r_d_ready;
  logic [1:0]  r_nbytes;
  logic [31:0] r_addr, r_data, r_rdata;
  logic [7:0]  r_status;
  logic [2:0]  r_resp_idx, r_resp_len;
  logic        w_cmd_ok;

  assign w_cmd_ok = (r_rx_shift == 8'h52) || (r_rx_shift == 8'h57);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_is_write <= 1'b0; r_d_ready <= 1'b0; r_nbytes <= '0; r_addr <= '0; r_data <= '0;
      r_rdata <= '0; r_status <= '0; r_resp_idx <= '0; r_resp_len <= '0;
    end else begin
      r_d_ready <= 1'b1;
      case (r_state)
        S_IDLE: if (w_rx_valid) begin
          r_is_write <= (r_rx_shift == 8'h57); r_nbytes <= '0; r_resp_idx <= '0;
          r_status <= 8'h03; r_rdata <= '0; r_resp_len <= 3'd1;
        end
        S_ADDR: if (w_rx_valid) begin
          r_addr <= {r_rx_shift, r_addr[31:8]}; r_nbytes <= r_nbytes + 1'b1;
        end
        S_DATA: if (w_rx_valid) begin
          r_data <= {r_rx_shift, r_data[31:8]}; r_nbytes <= r_nbytes + 1'b1;
        end
        S_REQ: if (!tl_i.a_ready && w_timeout) begin
          r_status <= 8'h02; r_rdata <= '0; r_resp_len <= r_is_write ? 3'd1 : 3'd5;
        end
        S_WAIT: if (tl_i.d_valid) begin
          r_status   <= tl_i.d_error ? 8'h01 : 8'h00;
          r_rdata    <= (tl_i.d_error || r_is_write) ? 32'h0 : tl_i.d_data;
          r_resp_len <= r_is_write ? 3'd1 : 3'd5;
        end else if (w_timeout) begin
          r_status <= 8'h02; r_rdata <= '0; r_resp_len <= r_is_write ? 3'd1 : 3'd5;
        end
        S_RESP: if (w_tx_load) r_resp_idx <= r_resp_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_resp_idx)
      3'd0:    w_tx_byte = r_status;
      3'd1:    w_tx_byte = r_rdata[7:0];
      3'd2:    w_tx_byte = r_rdata[15:8];
      3'd3:    w_tx_byte = r_rdata[23:16];
      default: w_tx_byte = r_rdata[31:24];
    endcase
  end

  // ---------------- Main FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_rx_valid) w_next = w_cmd_ok ? S_ADDR : S_RESP;
      S_ADDR: if (w_rx_ferr) w_next = S_IDLE;
              else if (w_rx_valid && r_nbytes == 2'd3) w_next = r_is_write ? S_DATA : S_REQ;
      S_DATA: if (w_rx_ferr) w_next = S_IDLE;
              else if (w_rx_valid && r_nbytes == 2'd3) w_next = S_REQ;
      S_REQ:  if (tl_i.a_ready) w_next = S_WAIT;
              else if (w_timeout) w_next = S_RESP;
      S_WAIT: if (tl_i.d_valid || w_timeout) w_next = S_RESP;
      S_RESP: if (w_tx_ready && r_resp_idx == r_resp_len) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  logic [31:0] w_a_addr, w_a_data;
  logic [2:0]  w_a_op;
  assign w_a_addr = {r_addr[31:2], 2'b00};
  assign w_a_data = r_is_write ? r_data : 32'h0;
  assign w_a_op   = r_is_write ? tlul_pkg::PutFullData : tlul_pkg::Get;

  always_comb begin
    tl_o         = '0;
    tl_o.d_ready = r_d_ready;
    if (r_state == S_REQ) begin
      tl_o.a_valid   = 1'b1;
      tl_o.a_opcode  = w_a_op;
      tl_o.a_size    = 2'd2;
      tl_o.a_mask    = 4'hF;
      tl_o.a_address = w_a_addr;
      tl_o.a_data    = w_a_data;
      tl_o.a_user    = tlul_pkg::tlul_cmd_intg_gen(w_a_addr, w_a_op, 4'hF, w_a_data);
    end
    w_tx_load = (r_state == S_RESP) && w_tx_ready && (r_resp_idx != r_resp_len);
    busy_o    = (r_state != S_IDLE);
  end

  logic w_unused_tl;
  assign w_unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink,
                         tl_i.d_user, r_addr[1:0]};
endmodule

// File: tb/tb_uart_tlul_dbg_host.sv
// Directed bench for uart_tlul_dbg_host at BitCycles=10: vector table plus framing/reset/timeout sequences.
module tb_uart_tlul_dbg_host;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx_o, busy_o;
  tlul_pkg::tl_h2d_t tl_o;
  tlul_pkg::tl_d2h_t tl_i;

  uart_tlul_dbg_host #(.ClockFrequency(50_000_000), .BaudRate(5_000_000), .TimeoutCycles(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx_o),
    .busy_o(busy_o), .tl_o(tl_o), .tl_i(tl_i));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int tx_stop_err = 0;

  // Responder configuration (written by the test only)
  int stall_req = 0;
  bit rsp_en = 1'b1;
  bit rsp_err = 1'b0;
  logic [31:0] rsp_data = '0;
  int spur_req = 0;
  // Responder observations (written by the responder only)
  int hs_count = 0;
  int stab_err = 0;
  logic [2:0] last_op;
  logic [31:0] last_addr, last_data;
  logic [3:0] last_mask;
  logic [1:0] last_size;
  logic [7:0] last_src;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          derr;
    int          stall;
    bit          en;
    int          exp_hs;
    logic [2:0]  exp_op;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_ntx;
    logic [39:0] exp_tx;
  } vec_t;
  vec_t vecs[8];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin : tl_responder
    int stall_cnt;
    int spur_done;
    bit d_pending;
    tlul_pkg::tl_h2d_t first;
    stall_cnt = 0; spur_done = 0; d_pending = 1'b0; first = '0;
    tl_i = '0;
    forever begin
      @(negedge clk);
      tl_i.d_valid = 1'b0;
      tl_i.a_ready = 1'b0;
      if (d_pending) begin
        tl_i.d_valid = 1'b1; tl_i.d_error = rsp_err; tl_i.d_data = rsp_data; d_pending = 1'b0;
      end else if (spur_req != spur_done) begin
        tl_i.d_valid = 1'b1; tl_i.d_error = 1'b0; tl_i.d_data = 32'hFFFF_FFFF; spur_done = spur_req;
      end
      if (tl_o.a_valid === 1'b1) begin
        if (stall_cnt == 0) first = tl_o;
        else if (tl_o !== first) stab_err++;
        if (stall_cnt >= stall_req) begin
          tl_i.a_ready = 1'b1;
          hs_count++;
          last_op = tl_o.a_opcode; last_addr = tl_o.a_address; last_data = tl_o.a_data;
          last_mask = tl_o.a_mask; last_size = tl_o.a_size; last_src = tl_o.a_source;
          d_pending = rsp_en;
          stall_cnt = 0;
        end else begin
          stall_cnt++;
        end
      end else begin
        stall_cnt = 0;
      end
    end
  end

  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx_o === 1'b0) begin
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = uart_tx_o;
        end
        repeat (10) @(negedge clk);
        if (uart_tx_o !== 1'b1) tx_stop_err++;
        got_q.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (10) @(negedge clk);
    end
    uart_rx = stop;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (stop ? 2 : 20) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout actual=busy expected=idle", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int hs0, base, st0, n;
    logic [7:0] e, a;
    stall_req = v.stall; rsp_err = v.derr; rsp_data = v.rdata; rsp_en = v.en;
    hs0 = hs_count; base = got_q.size(); st0 = stab_err;
    send_byte(v.cmd, 1'b1);
    if (v.cmd == 8'h52 || v.cmd == 8'h57)
      for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8], 1'b1);
    if (v.cmd == 8'h57)
      for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8], 1'b1);
    wait_idle(name);
    check_val({name, "_handshakes"}, 32'(hs_count - hs0), 32'(v.exp_hs));
    check_val({name, "_a_stable"}, 32'(stab_err - st0), 32'd0);
    if (v.exp_hs != 0) begin
      check_val({name, "_opcode"}, {29'd0, last_op}, {29'd0, v.exp_op});
      check_val({name, "_address"}, last_addr, v.exp_addr);
      check_val({name, "_a_data"}, last_data, v.exp_data);
      check_val({name, "_mask_size_src"}, {18'd0, last_mask, last_size, last_src}, {18'd0, 4'hF, 2'd2, 8'd0});
    end
    n = got_q.size() - base;
    check_val({name, "_tx_count"}, 32'(n), 32'(v.exp_ntx));
    for (int i = 0; i < v.exp_ntx; i++) exp_q.push_back(v.exp_tx[8*i +: 8]);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = (i < n) ? got_q[base + i] : 8'hxx;
      check_val($sformatf("%s_tx_byte%0d", name, i), {24'd0, a}, {24'd0, e});
    end
  endtask

  initial begin : main
    int hs0, g0;
    vec_t fresh;
    // cmd addr wdata rdata derr stall en | exp_hs op addr data ntx tx(byte0 in LSBs)
    vecs[0] = '{8'h57, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 1, 1, 3'd0, 32'h4000_0010, 32'hDEAD_BEEF, 1, 40'h00};
    vecs[1] = '{8'h52, 32'h4000_0007, 32'h0, 32'h1234_5678, 0, 0, 1, 1, 3'd4, 32'h4000_0004, 32'h0, 5, 40'h12_34_56_78_00};
    vecs[2] = '{8'h52, 32'h4000_0008, 32'h0, 32'hCAFE_F00D, 1, 0, 1, 1, 3'd4, 32'h4000_0008, 32'h0, 5, 40'h00_00_00_00_01};
    vecs[3] = '{8'h41, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0, 3'd0, 32'h0, 32'h0, 1, 40'h03};
    vecs[4] = '{8'h52, 32'h4000_0004, 32'h0, 32'h0BAD_C0DE, 0, 0, 1, 1, 3'd4, 32'h4000_0004, 32'h0, 5, 40'h0B_AD_C0_DE_00};
    vecs[5] = '{8'h57, 32'h2000_0ABE, 32'h0123_4567, 32'h0, 0, 20, 1, 1, 3'd0, 32'h2000_0ABC, 32'h0123_4567, 1, 40'h00};
    vecs[6] = '{8'h57, 32'h0000_0001, 32'h0, 32'h0, 1, 0, 1, 1, 3'd0, 32'h0, 32'h0, 1, 40'h01};
    vecs[7] = '{8'h52, 32'hFFFF_FFFF, 32'h0, 32'h8000_0001, 0, 3, 1, 1, 3'd4, 32'hFFFF_FFFC, 32'h0, 5, 40'h80_00_00_01_00};

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_tx", {31'd0, uart_tx_o}, 32'd1);
    check_val("rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("rst_a_valid_d_ready", {30'd0, tl_o.a_valid, tl_o.d_ready}, 32'd0);
    check_val("rst_a_address", tl_o.a_address, 32'd0);
    check_val("rst_a_user", {10'd0, tl_o.a_user}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check_val("d_ready_after_rst", {31'd0, tl_o.d_ready}, 32'd1);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Spurious d_valid while idle
    hs0 = hs_count; g0 = got_q.size();
    spur_req++;
    repeat (20) @(negedge clk);
    check_val("spurious_busy", {31'd0, busy_o}, 32'd0);
    check_val("spurious_tx", 32'(got_q.size() - g0), 32'd0);
    check_val("spurious_hs", 32'(hs_count - hs0), 32'd0);

    // Stop bit low on the third address byte drops the frame; a fresh frame runs alone
    hs0 = hs_count; g0 = got_q.size();
    stall_req = 0; rsp_en = 1'b1; rsp_err = 1'b0;
    send_byte(8'h52, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h40, 1'b0);
    check_val("ferr_busy", {31'd0, busy_o}, 32'd0);
    check_val("ferr_hs", 32'(hs_count - hs0), 32'd0);
    fresh = '{8'h52, 32'h4000_0004, 32'h0, 32'h1122_3344, 0, 0, 1, 1, 3'd4, 32'h4000_0004, 32'h0, 5, 40'h11_22_33_44_00};
    run_vec(fresh, "fresh");

    // Reset pulse while waiting for the response
    rsp_en = 1'b0; hs0 = hs_count;
    send_byte(8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
    for (int n = 0; n < 200 && hs_count == hs0; n++) @(negedge clk);
    check_val("wait_hs", 32'(hs_count - hs0), 32'd1);
    repeat (3) @(negedge clk);
    check_val("wait_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_val("rst_wait_a_valid", {31'd0, tl_o.a_valid}, 32'd0);
    check_val("rst_wait_tx", {31'd0, uart_tx_o}, 32'd1);
    check_val("rst_wait_busy", {31'd0, busy_o}, 32'd0);
    repeat (5) @(negedge clk);
    run_vec(vecs[4], "after_rst");

`ifdef UART_DBG_TIMEOUT_EN
    fresh = '{8'h52, 32'h4000_0004, 32'h0, 32'h5555_AAAA, 0, 0, 0, 1, 3'd4, 32'h4000_0004, 32'h0, 5, 40'h00_00_00_00_02};
    run_vec(fresh, "timeout");
    g0 = got_q.size();
    spur_req++;
    repeat (30) @(negedge clk);
    check_val("late_d_tx", 32'(got_q.size() - g0), 32'd0);
    check_val("late_d_busy", {31'd0, busy_o}, 32'd0);
    rsp_en = 1'b1;
`endif

    check_val("tx_stop_bits", 32'(tx_stop_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
